// File: rtl/alu_muldiv_sequencer.sv
// alu_muldiv_sequencer
// --------------------
// Multi-cycle sequencer for the RISC-V M-extension operations. It sits beside
// the EX-stage ALU. Multiplies use a 32-step shift-add loop, and divides use a
// 32-step restoring loop. BUSY is asserted for the whole operation so the
// pipeline can stall.
//
// Optional feature: define MULDIV_FASTZERO_EN to send zero-operand operations
// through the two-edge special-case path. These are a multiply with either
// operand zero, or a divide/remainder with a zero dividend and a non-zero
// divisor. When the macro is not defined, these operations take the full
// iterative path and produce the same RESULT.
//
// Ports
//   clk     rising-edge clock
//   reset   synchronous, active-high reset
//   start   launch request; only sampled while ready=1
//   kill    pipeline flush; aborts any operation in flight, and wins over start
//   funct3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//           100 DIV, 101 DIVU, 110 REM, 111 REMU
//   data1   rs1 (multiplicand / dividend)
//   data2   rs2 (multiplier / divisor)
//   result  registered result; held until the next completed operation
//   done    one-cycle pulse; result is valid in the same cycle
//   busy    high while an operation is in flight (stall request)
//   ready   high only in IDLE
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; operands are decoded and latched on accept
// CALC   | one multiply/divide iteration per edge, 32 iterations in total
// FIX    | sign correction and result select; result written on exit
// DONE   | done pulse for one cycle, then back to IDLE

module alu_muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            busy,
    output logic            ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    state_t state, state_next;

    logic [CNT_W-1:0] cnt;
    logic [2:0]       op;
    logic [XLEN-1:0]  opa;      // multiplicand or divisor magnitude
    logic [XLEN-1:0]  acc_hi;   // product high half / partial remainder
    logic [XLEN-1:0]  acc_lo;   // product low half / quotient, or special-case value
    logic             neg_q;    // negate product or quotient
    logic             neg_r;    // negate remainder (follows dividend)
    logic             special_q;

    // Decode of the incoming operation, used only at acceptance
    logic            accept;
    logic            sgn1, sgn2, neg1, neg2;
    logic [XLEN-1:0] mag1, mag2;
    logic            div_zero, div_ovf, fast_zero, special;
    logic [XLEN-1:0] special_val;

    // Iteration datapath
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic            div_ge;
    logic [XLEN-1:0] div_diff;

    // Result select
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, fix_result;

    assign accept = (state == S_IDLE) && start && !kill;

    always_comb begin
        sgn1 = 1'b0;
        sgn2 = 1'b0;
        case (funct3)
            3'b001, 3'b100, 3'b110: begin
                sgn1 = 1'b1;
                sgn2 = 1'b1;
            end
            3'b010:  sgn1 = 1'b1;
            default: ;
        endcase
        neg1 = sgn1 && data1[XLEN-1];
        neg2 = sgn2 && data2[XLEN-1];
        mag1 = neg1 ? -data1 : data1;
        mag2 = neg2 ? -data2 : data2;

        div_zero = funct3[2] && (data2 == '0);
        div_ovf  = funct3[2] && !funct3[0] && (data1 == MIN_NEG) && (data2 == ALL_ONES);
`ifdef MULDIV_FASTZERO_EN
        fast_zero = (!funct3[2] && ((data1 == '0) || (data2 == '0))) ||
                    ( funct3[2] && (data1 == '0) && (data2 != '0));
`else
        fast_zero = 1'b0;
`endif
        special = div_zero || div_ovf || fast_zero;

        // Divide-by-zero is checked first, so it takes priority over the zero shortcut
        special_val = '0;
        if (div_zero)
            special_val = funct3[1] ? data1 : ALL_ONES;
        else if (div_ovf)
            special_val = funct3[1] ? '0 : MIN_NEG;
    end

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opa} : '0);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_ge    = div_shift >= {1'b0, opa};
        // When div_ge holds the true difference is below opa, so XLEN bits are enough
        div_diff  = div_shift[XLEN-1:0] - opa;
    end

    always_comb begin
        prod   = {acc_hi, acc_lo};
        prod_s = neg_q ? -prod : prod;
        quo_s  = neg_q ? -acc_lo : acc_lo;
        rem_s  = neg_r ? -acc_hi : acc_hi;
        fix_result = '0;
        if (special_q) begin
            fix_result = acc_lo;
        end else begin
            case (op)
                3'b000:                 fix_result = prod_s[XLEN-1:0];
                3'b001, 3'b010, 3'b011: fix_result = prod_s[2*XLEN-1:XLEN];
                3'b100, 3'b101:         fix_result = quo_s;
                default:                fix_result = rem_s;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept)
                    state_next = special ? S_FIX : S_CALC;
            end
            S_CALC: begin
                if (kill)
                    state_next = S_IDLE;
                else if (cnt == CNT_W'(XLEN-1))
                    state_next = S_FIX;
            end
            S_FIX:   state_next = kill ? S_IDLE : S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            op        <= '0;
            opa       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            special_q <= 1'b0;
            result    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op        <= funct3;
                        cnt       <= '0;
                        acc_hi    <= '0;
                        neg_q     <= neg1 ^ neg2;
                        neg_r     <= neg1;
                        special_q <= special;
                        if (funct3[2]) begin
                            opa    <= mag2;
                            acc_lo <= special ? special_val : mag1;
                        end else begin
                            opa    <= mag1;
                            acc_lo <= special ? special_val : mag2;
                        end
                    end
                end
                S_CALC: begin
                    cnt <= cnt + 1'b1;
                    if (op[2]) begin
                        acc_hi <= div_ge ? div_diff : div_shift[XLEN-1:0];
                        acc_lo <= {acc_lo[XLEN-2:0], div_ge};
                    end else begin
                        acc_hi <= mul_sum[XLEN:1];
                        acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
                    end
                end
                S_FIX: begin
                    if (!kill)
                        result <= fix_result;
                end
                default: ;
            endcase
        end
    end

    assign done  = (state == S_DONE);
    assign busy  = (state != S_IDLE);
    assign ready = (state == S_IDLE);

endmodule
